// File: rtl/xlr_mem_bank.sv
// Banked line memory behind the accelerator memory port. The accelerator owns every bank it
// touches in a cycle; host accesses are slotted into cycles where the target bank is idle.
//
// state  | meaning
// S_IDLE | no host access outstanding; a new request is evaluated in the same cycle
// S_ARB  | host request held off by accelerator traffic on its bank
// S_RESP | host read data presented with host_rvalid
module xlr_mem_bank #(
    parameter  int NUM_MEMS           = 2,
    parameter  int LOG2_LINES_PER_MEM = 8,
    parameter  int LINE_BITS          = 256,
    localparam int BE_BITS            = LINE_BITS / 8,
    localparam int SEL_W              = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1,
    localparam int LINES              = 1 << LOG2_LINES_PER_MEM
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
    input  logic [NUM_MEMS-1:0][LINE_BITS-1:0]            xlr_mem_wdata,
    input  logic [NUM_MEMS-1:0][BE_BITS-1:0]              xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                           xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                           xlr_mem_wr,
    output logic [NUM_MEMS-1:0][LINE_BITS-1:0]            xlr_mem_rdata,
    input  logic                                          host_req,
    input  logic                                          host_we,
    input  logic [SEL_W-1:0]                              host_sel,
    input  logic [LOG2_LINES_PER_MEM-1:0]                 host_addr,
    input  logic [LINE_BITS-1:0]                          host_wdata,
    input  logic [BE_BITS-1:0]                            host_be,
    output logic                                          host_gnt,
    output logic                                          host_rvalid,
    output logic [LINE_BITS-1:0]                          host_rdata,
    output logic                                          host_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_RESP = 2'd2
    } host_state_t;

    host_state_t state_q, state_d;
    logic [15:0] starve_cnt;

    logic [NUM_MEMS-1:0][LINE_BITS-1:0] bank_line;
    logic [LINE_BITS-1:0]               host_line;
    logic sel_valid, bank_busy;
    logic gnt, err, rvalid, blocked;

    assign sel_valid = (int'(host_sel) < NUM_MEMS);

    // An out-of-range select matches no bank, so it is never busy and reads back zero.
    always_comb begin
        bank_busy = 1'b0;
        host_line = '0;
        for (int b = 0; b < NUM_MEMS; b++) begin
            if (host_sel == SEL_W'(b)) begin
                bank_busy = xlr_mem_rd[b] | xlr_mem_wr[b];
                host_line = bank_line[b];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        err     = 1'b0;
        rvalid  = 1'b0;
        blocked = 1'b0;
        case (state_q)
            S_IDLE, S_ARB: begin
                if (host_req) begin
                    if (bank_busy) begin
                        blocked = 1'b1;
                        state_d = S_ARB;
                    end else begin
                        gnt     = 1'b1;
                        err     = ~sel_valid;
                        state_d = host_we ? S_IDLE : S_RESP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                rvalid  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset drops any pending request, so no grant or host write can slip through.
        if (rst) begin
            gnt     = 1'b0;
            err     = 1'b0;
            rvalid  = 1'b0;
            blocked = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            starve_cnt <= '0;
            host_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (gnt) begin
                starve_cnt <= '0;
            end else if (blocked && (starve_cnt != 16'hFFFF)) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
            if (gnt && !host_we) begin
                host_rdata <= host_line;
            end
        end
    end

    assign host_gnt    = gnt;
    assign host_err    = err;
    assign host_rvalid = rvalid;

    for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
        logic [LINE_BITS-1:0]          mem [LINES];
        logic [LINE_BITS-1:0]          rdata_q;
        logic [LOG2_LINES_PER_MEM-1:0] port_addr;
        logic [LINE_BITS-1:0]          port_wdata;
        logic [BE_BITS-1:0]            port_be;
        logic                          xlr_busy, host_wr, port_we;

        // Host only ever reaches a bank in cycles the accelerator leaves it alone,
        // so one shared port per bank suffices.
        assign xlr_busy   = xlr_mem_rd[b] | xlr_mem_wr[b];
        assign host_wr    = gnt & host_we & (host_sel == SEL_W'(b));
        assign port_addr  = xlr_busy ? xlr_mem_addr[b] : host_addr;
        assign port_we    = xlr_mem_wr[b] | host_wr;
        assign port_wdata = xlr_mem_wr[b] ? xlr_mem_wdata[b] : host_wdata;
        assign port_be    = xlr_mem_wr[b] ? xlr_mem_be[b] : host_be;
        assign bank_line[b] = mem[port_addr];

        always_ff @(posedge clk) begin
            if (port_we) begin
                for (int i = 0; i < BE_BITS; i++) begin
                    if (port_be[i]) begin
                        mem[port_addr][i*8 +: 8] <= port_wdata[i*8 +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (xlr_mem_rd[b]) begin
                rdata_q <= bank_line[b];
            end
        end

        assign xlr_mem_rdata[b] = rdata_q;
    end

endmodule

// File: tb/tb_xlr_mem_bank.sv
// Directed bench for xlr_mem_bank: stimulus pushes expected responses into queues and a
// negedge monitor pops and compares them whenever the DUT presents data or a grant.
module tb_xlr_mem_bank;

    localparam int NM = 3;
    localparam int AW = 8;
    localparam int LB = 256;
    localparam int BB = LB / 8;

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0][AW-1:0] xlr_mem_addr;
    logic [NM-1:0][LB-1:0] xlr_mem_wdata;
    logic [NM-1:0][BB-1:0] xlr_mem_be;
    logic [NM-1:0]         xlr_mem_rd;
    logic [NM-1:0]         xlr_mem_wr;
    logic [NM-1:0][LB-1:0] xlr_mem_rdata;
    logic                  host_req, host_we;
    logic [1:0]            host_sel;
    logic [AW-1:0]         host_addr;
    logic [LB-1:0]         host_wdata;
    logic [BB-1:0]         host_be;
    logic                  host_gnt, host_rvalid, host_err;
    logic [LB-1:0]         host_rdata;

    xlr_mem_bank #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW), .LINE_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .xlr_mem_addr(xlr_mem_addr), .xlr_mem_wdata(xlr_mem_wdata), .xlr_mem_be(xlr_mem_be),
        .xlr_mem_rd(xlr_mem_rd), .xlr_mem_wr(xlr_mem_wr), .xlr_mem_rdata(xlr_mem_rdata),
        .host_req(host_req), .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_be(host_be), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            bank;
        logic [LB-1:0] data;
    } acc_exp_t;

    acc_exp_t      acc_q[$];
    logic          gnt_q[$];
    logic [LB-1:0] host_q[$];
    logic [NM-1:0] rd_pend = '0;
    int checks = 0;
    int failures = 0;

    localparam logic [LB-1:0] V_A5    = {32{8'hA5}};
    localparam logic [LB-1:0] V_11    = {32{8'h11}};
    localparam logic [LB-1:0] V_BE    = {{28{8'h11}}, {4{8'hFF}}};
    localparam logic [LB-1:0] V_1234  = 256'h1234;
    localparam logic [LB-1:0] V_BEEF  = 256'hBEEF;
    localparam logic [LB-1:0] V_3C    = {32{8'h3C}};
    localparam logic [LB-1:0] V_C3    = {32{8'hC3}};
    localparam logic [LB-1:0] V_69    = {32{8'h69}};
    localparam logic [LB-1:0] V_D0    = {16{16'hD0D0}};
    localparam logic [LB-1:0] V_D1    = {8{32'h0123_4567}};

    task automatic chk_line(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    always @(negedge clk) begin
        for (int b = 0; b < NM; b++) begin
            if (rd_pend[b]) begin
                acc_exp_t e;
                if (acc_q.size() == 0) begin
                    flag("acc_rdata_unexpected");
                end else begin
                    e = acc_q.pop_front();
                    chk_int("acc_bank_order", e.bank, b);
                    chk_line($sformatf("acc_rdata%0d", b), xlr_mem_rdata[b], e.data);
                end
            end
        end
        rd_pend = rst ? '0 : xlr_mem_rd;
        if (host_gnt) begin
            if (gnt_q.size() == 0) flag("gnt_unexpected");
            else chk_bit("gnt_err", host_err, gnt_q.pop_front());
        end else if (host_err) begin
            flag("err_without_gnt");
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) flag("rvalid_unexpected");
            else chk_line("host_rdata", host_rdata, host_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_rd(input int b, input logic [AW-1:0] a, input logic [LB-1:0] exp);
        xlr_mem_rd[b]   = 1'b1;
        xlr_mem_addr[b] = a;
        acc_q.push_back('{bank: b, data: exp});
        tick();
        xlr_mem_rd[b] = 1'b0;
    endtask

    task automatic acc_rd_burst(input int b, input logic [AW-1:0] a, input int n,
                                input logic [LB-1:0] exp);
        xlr_mem_rd[b]   = 1'b1;
        xlr_mem_addr[b] = a;
        for (int i = 0; i < n; i++) begin
            acc_q.push_back('{bank: b, data: exp});
            tick();
        end
        xlr_mem_rd[b] = 1'b0;
    endtask

    task automatic acc_wr(input int b, input logic [AW-1:0] a, input logic [LB-1:0] d,
                          input logic [BB-1:0] be);
        xlr_mem_wr[b]    = 1'b1;
        xlr_mem_addr[b]  = a;
        xlr_mem_wdata[b] = d;
        xlr_mem_be[b]    = be;
        tick();
        xlr_mem_wr[b] = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [1:0] sel, input logic [AW-1:0] a,
                           input logic [LB-1:0] wd, input logic [BB-1:0] be,
                           input logic exp_err, input logic [LB-1:0] exp_rd,
                           output int waited, output int starve);
        bit got = 1'b0;
        host_req   = 1'b1;
        host_we    = we;
        host_sel   = sel;
        host_addr  = a;
        host_wdata = wd;
        host_be    = be;
        gnt_q.push_back(exp_err);
        if (!we) host_q.push_back(exp_rd);
        waited = 0;
        starve = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (host_gnt) begin
                got    = 1'b1;
                starve = int'(dut.starve_cnt);
            end else begin
                waited++;
                tick();
            end
        end
        if (!got) begin
            flag("gnt_timeout");
            void'(gnt_q.pop_back());
            if (!we) void'(host_q.pop_back());
        end
        tick();
        host_req = 1'b0;
        if (!we && got) begin
            @(negedge clk);
            chk_bit("rvalid_after_gnt", host_rvalid, 1'b1);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, s, w2, s2;
        rst           = 1'b1;
        xlr_mem_addr  = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be    = '0;
        xlr_mem_rd    = '0;
        xlr_mem_wr    = '0;
        host_req      = 1'b1;
        host_we       = 1'b0;
        host_sel      = 2'd0;
        host_addr     = '0;
        host_wdata    = '0;
        host_be       = '0;

        // reset: a free-bank request during rst must not be granted
        tick();
        tick();
        for (int b = 0; b < NM; b++) chk_line($sformatf("rst_rdata%0d", b), xlr_mem_rdata[b], '0);
        chk_line("rst_host_rdata", host_rdata, '0);
        chk_bit("rst_gnt", host_gnt, 1'b0);
        chk_bit("rst_rvalid", host_rvalid, 1'b0);
        chk_bit("rst_err", host_err, 1'b0);
        chk_int("rst_fsm", int'(dut.state_q), 0);
        chk_int("rst_starve", int'(dut.starve_cnt), 0);
        host_req = 1'b0;
        rst      = 1'b0;

        host_op(1'b1, 2'd0, 8'h00, V_A5, '1, 1'b0, '0, w, s);
        chk_int("hwr_wait", w, 0);
        acc_rd(0, 8'h00, V_A5);

        host_op(1'b1, 2'd1, 8'h7F, V_11, '1, 1'b0, '0, w, s);
        acc_wr(1, 8'h7F, '1, 32'h0000_000F);
        acc_rd(1, 8'h7F, V_BE);

        acc_wr(0, 8'h10, V_1234, '1);
        xlr_mem_rd[0]    = 1'b1;
        xlr_mem_wr[0]    = 1'b1;
        xlr_mem_addr[0]  = 8'h10;
        xlr_mem_wdata[0] = V_BEEF;
        xlr_mem_be[0]    = '1;
        acc_q.push_back('{bank: 0, data: V_1234});
        tick();
        xlr_mem_rd[0] = 1'b0;
        xlr_mem_wr[0] = 1'b0;
        acc_rd(0, 8'h10, V_BEEF);
        tick();
        chk_line("rdata_hold", xlr_mem_rdata[0], V_BEEF);

        // host read blocked 5 cycles by accelerator reads on the same bank
        fork
            acc_rd_burst(0, 8'h00, 5, V_A5);
            host_op(1'b0, 2'd0, 8'h10, '0, '0, 1'b0, V_BEEF, w, s);
        join
        chk_int("arb_wait", w, 5);
        chk_int("arb_starve_peak", s, 5);
        chk_int("starve_cleared", int'(dut.starve_cnt), 0);

        fork
            acc_rd_burst(0, 8'h00, 5, V_A5);
            host_op(1'b0, 2'd1, 8'h7F, '0, '0, 1'b0, V_BE, w2, s2);
        join
        chk_int("other_bank_wait", w2, 0);

        // out-of-range select: write must touch no bank, read returns zero
        acc_wr(0, 8'h20, V_3C, '1);
        acc_wr(1, 8'h20, V_C3, '1);
        acc_wr(2, 8'h20, V_69, '1);
        host_op(1'b1, 2'd3, 8'h20, '1, '1, 1'b1, '0, w, s);
        chk_int("bad_sel_wr_wait", w, 0);
        acc_rd(0, 8'h20, V_3C);
        acc_rd(1, 8'h20, V_C3);
        acc_rd(2, 8'h20, V_69);
        host_op(1'b0, 2'd3, 8'h20, '0, '0, 1'b1, '0, w, s);
        chk_int("bad_sel_rd_wait", w, 0);

        // reset while a host read is blocked by accelerator writes
        xlr_mem_wr[0]    = 1'b1;
        xlr_mem_addr[0]  = 8'h30;
        xlr_mem_wdata[0] = V_D0;
        xlr_mem_be[0]    = '1;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_sel  = 2'd0;
        host_addr = 8'h30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit("blocked_no_gnt", host_gnt, 1'b0);
            tick();
        end
        chk_int("blocked_starve", int'(dut.starve_cnt), 3);
        rst              = 1'b1;
        xlr_mem_wdata[0] = V_D1;
        @(negedge clk);
        chk_bit("midrst_gnt", host_gnt, 1'b0);
        tick();
        rst           = 1'b0;
        host_req      = 1'b0;
        xlr_mem_wr[0] = 1'b0;
        chk_int("midrst_fsm", int'(dut.state_q), 0);
        chk_int("midrst_starve", int'(dut.starve_cnt), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_bit("midrst_rvalid", host_rvalid, 1'b0);
            tick();
        end
        host_op(1'b0, 2'd0, 8'h30, '0, '0, 1'b0, V_D1, w, s);
        chk_int("after_rst_wait", w, 0);

        tick();
        tick();
        chk_int("acc_q_drained", acc_q.size(), 0);
        chk_int("gnt_q_drained", gnt_q.size(), 0);
        chk_int("host_q_drained", host_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
